// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared encodings and register offsets for the interrupt arbiter
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [3:0]  PEND_OFS = 4'd0;
  localparam logic [3:0]  MASK_OFS = 4'd4;
  localparam logic [3:0]  ID_OFS   = 4'd8;
  localparam logic [31:0] NO_ID    = 32'hFFFF_FFFF;

endpackage

// File: rtl/irq_arbiter_priority_encoder.sv
// rtl/irq_arbiter_priority_encoder.sv - lowest-index-wins encoder over the eligible sources
module priority_encoder #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [3:0]         idx,
  output logic               valid
);

  // Scanning downward lets the lowest set index overwrite any higher one.
  always_comb begin
    idx = 4'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - edge-latched, masked, fixed-priority interrupt arbiter feeding cp0
module irq_arbiter
  import irq_pkg::*;
#(
  parameter int          NUM_SRC   = 4,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [31:0]        address,
  input  logic [31:0]        wr_data,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               eret,
  input  logic               int_taken,
  output logic               io_hit,
  output logic [31:0]        rd_data,
  output logic               int_req,
  output logic [3:0]         irq_id,
  output logic               in_service
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] prev_src_q, prev_src_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [3:0]         irq_id_q, irq_id_d;

  logic [NUM_SRC-1:0] eligible;
  logic [3:0]         winner;
  logic               winner_valid;
  logic               wr_pend, wr_mask;
  logic               unused_ok;

  assign io_hit  = (address[31:4] == BASE_ADDR[31:4]) && (address[3:2] != 2'b11);
  assign wr_pend = io_hit && MemWrite && (address[3:2] == PEND_OFS[3:2]);
  assign wr_mask = io_hit && MemWrite && (address[3:2] == MASK_OFS[3:2]);
  assign unused_ok = ^{address[1:0], wr_data};

  assign eligible = pending_q & mask_q;

  priority_encoder #(.NUM_SRC(NUM_SRC)) u_prio (
    .req   (eligible),
    .idx   (winner),
    .valid (winner_valid)
  );

  always_comb begin
    rd_data = 32'd0;
    if (io_hit && MemRead) begin
      case (address[3:2])
        PEND_OFS[3:2]: rd_data = 32'(pending_q);
        MASK_OFS[3:2]: rd_data = 32'(mask_q);
        ID_OFS[3:2]:   rd_data = (state_q == SERVICE) ? {28'd0, irq_id_q} : NO_ID;
        default:       rd_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    prev_src_d = irq_src;
    // A fresh edge is ORed in after the W1C so set beats clear.
    pending_d  = (pending_q & ~(wr_pend ? wr_data[NUM_SRC-1:0] : '0)) | (irq_src & ~prev_src_q);
    mask_d     = wr_mask ? wr_data[NUM_SRC-1:0] : mask_q;
    state_d    = state_q;
    irq_id_d   = irq_id_q;
    case (state_q)
      IDLE: begin
        if (winner_valid) state_d = REQ;
      end
      REQ: begin
        if (int_taken) begin
          state_d  = SERVICE;
          irq_id_d = winner;
        end else if (!winner_valid) begin
          state_d = IDLE;
        end
      end
      SERVICE: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      prev_src_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_id_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      prev_src_q <= prev_src_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign int_req    = (state_q == REQ);
  assign in_service = (state_q == SERVICE);
  assign irq_id     = irq_id_q;

endmodule
